// File: rtl/layer_weight_dispatch.sv
// Weight dispatcher: buffers an upstream stream of weight words in a small
// FIFO and hands them out in order to three conv ports, COUNT1 words to
// port 1, then COUNT2 words to port 2, then COUNT3 words to port 3. After
// that it pulses done for one cycle.
module layer_weight_dispatch #(
    parameter int DATA_WIDTH = 32,
    parameter int COUNT1     = 262144,
    parameter int COUNT2     = 589824,
    parameter int COUNT3     = 262144,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  hold,
    output logic                  valid_weight_out1,
    output logic                  valid_weight_out2,
    output logic                  valid_weight_out3,
    output logic [DATA_WIDTH-1:0] weight_out1,
    output logic [DATA_WIDTH-1:0] weight_out2,
    output logic [DATA_WIDTH-1:0] weight_out3,
    output logic                  busy,
    output logic                  done
);

    localparam int TOTAL  = COUNT1 + COUNT2 + COUNT3;
    localparam int MAX12  = (COUNT1 > COUNT2) ? COUNT1 : COUNT2;
    localparam int MAXC   = (MAX12 > COUNT3) ? MAX12 : COUNT3;
    localparam int PW     = $clog2(MAXC + 1);
    localparam int ACW    = $clog2(TOTAL + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SEND1, SEND2, SEND3, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           fill;
    logic                  full, empty, sending, wr_en, pop, last_pop;
    logic [PW-1:0]         pop_cnt, cur_count;
    logic [ACW-1:0]        acc_cnt;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full     = (fill == (AW+1)'(FIFO_DEPTH));
    assign empty    = (fill == '0);
    assign rd_data  = mem[rd_ptr];
    // The pop that completes the current port's quota also advances the FSM
    assign last_pop = pop && ((pop_cnt + PW'(1)) == cur_count);

    // Word quota of the port currently being served
    always_comb begin
        cur_count = PW'(COUNT1);
        case (state)
            SEND2:   cur_count = PW'(COUNT2);
            SEND3:   cur_count = PW'(COUNT3);
            default: cur_count = PW'(COUNT1);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = SEND1;
            SEND1:   if (last_pop) state_nxt = SEND2;
            SEND2:   if (last_pop) state_nxt = SEND3;
            SEND3:   if (last_pop) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // State-derived controls; s_ready uses pre-edge fullness, so a pop does
    // not open a slot for a write in the same cycle
    always_comb begin
        sending = (state == SEND1) || (state == SEND2) || (state == SEND3);
        busy    = (state != IDLE);
        s_ready = sending && !full && (acc_cnt < ACW'(TOTAL));
        wr_en   = s_valid && s_ready;
        pop     = sending && !empty && !hold;
    end

    // Accept and pop counters; neither can wrap because acceptance stops at
    // TOTAL and the pop count resets on every quota boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_cnt <= '0;
            pop_cnt <= '0;
        end else if (state == IDLE && start) begin
            acc_cnt <= '0;
            pop_cnt <= '0;
        end else begin
            if (wr_en)         acc_cnt <= acc_cnt + ACW'(1);
            if (last_pop)      pop_cnt <= '0;
            else if (pop)      pop_cnt <= pop_cnt + PW'(1);
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // FIFO storage; contents need no reset, the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s_data;
    end

    // Registered port outputs; data words hold between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_weight_out1 <= 1'b0;
            valid_weight_out2 <= 1'b0;
            valid_weight_out3 <= 1'b0;
            weight_out1       <= '0;
            weight_out2       <= '0;
            weight_out3       <= '0;
            done              <= 1'b0;
        end else begin
            valid_weight_out1 <= pop && (state == SEND1);
            valid_weight_out2 <= pop && (state == SEND2);
            valid_weight_out3 <= pop && (state == SEND3);
            if (pop && state == SEND1) weight_out1 <= rd_data;
            if (pop && state == SEND2) weight_out2 <= rd_data;
            if (pop && state == SEND3) weight_out3 <= rd_data;
            done              <= (state == DONE);
        end
    end

endmodule

// File: doc/layer_weight_dispatch.md
LAYER_WEIGHT_DISPATCH -- requirements
Module: layer_weight_dispatch

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line as name, default, meaning:
  DATA_WIDTH, 32, weight word width (FP32);
  COUNT1, 262144, words for conv1 port (1x1, 1024->256);
  COUNT2, 589824, words for conv2 port (3x3, 256->256);
  COUNT3, 262144, words for conv3 port (1x1, 256->1024);
  FIFO_DEPTH, 16, input FIFO entries (power of two, >=2).
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
  clk, in, 1, clock;
  reset, in, 1, asynchronous active-low reset;
  start, in, 1, begin one dispatch sequence;
  s_valid, in, 1, upstream weight word valid;
  s_data, in, DATA_WIDTH, upstream weight word;
  s_ready, out, 1, block accepts s_data this cycle;
  hold, in, 1, downstream stall, no dispatch while high;
  valid_weight_out1/2/3, out, 1, weight strobe to conv1/2/3;
  weight_out1/2/3, out, DATA_WIDTH, weight word to conv1/2/3;
  busy, out, 1, sequence in progress;
  done, out, 1, one-cycle pulse at end of sequence.

Function
REQ-004 The FSM SHALL have the states IDLE, SEND1, SEND2, SEND3 and DONE.
REQ-005 In IDLE, start=1 SHALL move the FSM to SEND1 and clear the dispatch and accept counters; start SHALL be ignored in every other state.
REQ-006 busy SHALL be 1 in SEND1, SEND2, SEND3 and DONE, and 0 in IDLE.
REQ-007 s_ready SHALL equal (state in SEND1..SEND3) AND (FIFO not full) AND (accept count < COUNT1+COUNT2+COUNT3).
REQ-008 A word SHALL be written when s_valid and s_ready are both 1; a pop in the same cycle SHALL NOT free space for that cycle's write, because s_ready is computed from the pre-edge fullness.
REQ-009 A pop SHALL occur when the FIFO is not empty, hold=0 and the state is SENDx.
REQ-010 On a pop, valid_weight_outX of the current state SHALL be 1 in the next cycle, with weight_outX equal to the popped word; the other two strobes SHALL be 0 in that cycle.
REQ-011 Minimum latency SHALL be 2 cycles: a word accepted at edge E is presented on the port from edge E+2.
REQ-012 Words SHALL be dispatched in FIFO order with no loss or duplication.
REQ-013 When the pop count reaches COUNTx within SENDx, the FSM SHALL move to the next state (SEND1->SEND2->SEND3->DONE) on that pop edge and reset the pop count.
REQ-014 DONE SHALL last exactly 1 cycle, asserting done=1 registered, then return to IDLE; done SHALL coincide with the cycle after the final strobe.
REQ-015 hold=1 SHALL freeze popping and counters; acceptance SHALL continue until the FIFO is full.
REQ-016 weight_outX SHALL hold its last dispatched value while valid_weight_outX=0.
REQ-017 Pop and dispatch counter widths SHALL be clog2(max COUNTx + 1); accept counter width SHALL be clog2(total + 1); counters SHALL never wrap.
REQ-018 COUNTx SHALL be >= 1; zero counts are unsupported.

Reset
REQ-019 reset=0 SHALL asynchronously force IDLE, empty the FIFO, clear all counters, and drive all outputs to 0 (s_ready, busy, done, strobes, weight_outX), including mid-sequence.
REQ-020 After reset release, no strobe SHALL occur until a new start is accepted.

Verification (COUNT1=3, COUNT2=2, COUNT3=4, FIFO_DEPTH=4)
REQ-021 Continuous stream: start, then s_valid=1 with words 1..9 back-to-back and hold=0 -> the block SHALL produce:
  - port1 = 1,2,3; port2 = 4,5; port3 = 6,7,8,9;
  - one strobe per cycle;
  - done one cycle after word 9;
  - s_ready=0 after the 9th acceptance; a 10th word is not accepted.
REQ-022 Stall: hold=1 while words 1..6 are offered -> the block SHALL accept exactly 4, then s_ready=0 and no strobes; after hold=0 it SHALL dispatch 1,2,3 on port1 and 4 on port2 in consecutive cycles.
REQ-023 Gapped input: s_valid toggling 1,0,1,0 -> strobes SHALL appear only for accepted words, and the port transitions SHALL occur exactly after the 3rd and 5th words.
REQ-024 start pulsed during SEND2 -> the block SHALL show no effect, with counts and sequence unchanged.
REQ-025 reset=0 asserted in SEND2 after word 4 -> all outputs SHALL be 0 immediately; after release and a new start, words 1..9 SHALL dispatch from port1 with the FIFO empty at start.
